// File: rtl/dac_mode_sequencer_pkg.sv
// Shared types and default timing for the DAC mode sequencer.
// Holds the FSM state encoding and the production timing defaults.
package common;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    MUTE     = 3'd2,
    RESET    = 3'd3,
    SWITCH   = 3'd4,
    SETTLE   = 3'd5,
    RELEASE  = 3'd6
  } seq_state_t;

  localparam int DEF_CFG_W      = 8;
  localparam int DEF_STABLE_CYC = 4096;
  localparam int DEF_MUTE_CYC   = 65536;
  localparam int DEF_RESET_CYC  = 1024;
  localparam int DEF_SETTLE_CYC = 262144;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchronizer for quasi-static control inputs.
// Reset clears both stages so the synchronized value starts at 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/dac_mode_sequencer.sv
// Debounces a requested DAC configuration and applies it through a
// mute -> reset -> switch -> settle -> release -> unmute sequence.
module dac_mode_sequencer
  import common::*;
#(
  parameter int               CFG_W      = DEF_CFG_W,
  parameter logic [CFG_W-1:0] CFG_RESET  = '0,
  parameter int               STABLE_CYC = DEF_STABLE_CYC,
  parameter int               MUTE_CYC   = DEF_MUTE_CYC,
  parameter int               RESET_CYC  = DEF_RESET_CYC,
  parameter int               SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CFG_W-1:0] cfg_in,
  input  logic             mcu_mute,
  input  logic             mcu_rst,
  output logic [CFG_W-1:0] cfg_out,
  output logic             dac_mute,
  output logic             dac_rst,
  output logic             busy,
  output seq_state_t       dbg_state
);

  localparam int MAX_CYC = max4(STABLE_CYC, MUTE_CYC, RESET_CYC, SETTLE_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  if (STABLE_CYC < 1 || MUTE_CYC < 1 || RESET_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_param
    $error("dac_mode_sequencer: all timing parameters must be >= 1");
  end

  logic [CFG_W-1:0] cfg_s;
  logic             mute_s;
  logic             rst_s;

  sync_2ff #(.W(CFG_W)) u_sync_cfg (
    .clk_i (clk),
    .rst_ni(resetn),
    .d_i   (cfg_in),
    .q_o   (cfg_s)
  );

  sync_2ff #(.W(1)) u_sync_mute (
    .clk_i (clk),
    .rst_ni(resetn),
    .d_i   (mcu_mute),
    .q_o   (mute_s)
  );

  sync_2ff #(.W(1)) u_sync_rst (
    .clk_i (clk),
    .rst_ni(resetn),
    .d_i   (mcu_rst),
    .q_o   (rst_s)
  );

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cand_q, cand_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             mute_q, rst_q, busy_q;
  logic             last_cyc;
  logic             restart;

  // Duration loaded into the shared down-counter when a state is entered.
  function automatic logic [CNT_W-1:0] load_val(input seq_state_t s);
    case (s)
      DEBOUNCE:         return CNT_W'(STABLE_CYC);
      MUTE, RELEASE:    return CNT_W'(MUTE_CYC);
      RESET:            return CNT_W'(RESET_CYC);
      SETTLE:           return CNT_W'(SETTLE_CYC);
      default:          return CNT_W'(1);
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cfg_d    = cfg_q;
    restart  = 1'b0;
    last_cyc = (cnt_q == CNT_W'(1));
    case (state_q)
      IDLE: begin
        if (cfg_s != cfg_q) begin
          cand_d  = cfg_s;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (cfg_s == cfg_q) begin
          state_d = IDLE;
        end else if (cfg_s != cand_q) begin
          cand_d  = cfg_s;
          restart = 1'b1;
        end else if (last_cyc) begin
          state_d = MUTE;
        end
      end
      MUTE:    if (last_cyc) state_d = RESET;
      RESET: begin
        if (last_cyc) begin
          state_d = SWITCH;
          cfg_d   = cand_q;
        end
      end
      SWITCH:  state_d = SETTLE;
      SETTLE:  if (last_cyc) state_d = RELEASE;
      RELEASE: if (last_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q || restart) begin
      cnt_d = load_val(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs are decoded from the next state so they line up with state entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SETTLE;
      cnt_q   <= CNT_W'(SETTLE_CYC);
      cand_q  <= CFG_RESET;
      cfg_q   <= CFG_RESET;
      mute_q  <= 1'b1;
      rst_q   <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      cfg_q   <= cfg_d;
      mute_q  <= mute_s | (state_d inside {MUTE, RESET, SWITCH, SETTLE, RELEASE});
      rst_q   <= rst_s | (state_d inside {RESET, SWITCH, SETTLE});
      busy_q  <= !(state_d inside {IDLE, DEBOUNCE});
    end
  end

  assign cfg_out   = cfg_q;
  assign dac_mute  = mute_q;
  assign dac_rst   = rst_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: doc/dac_mode_sequencer.md
# dac_mode_sequencer

Sequences every DAC mode change (sample-rate family, rate multiplier, DSD/PCM, NOS routing, MCLK ratio) so that the DAC is never fed a switching clock or stream while live. Sits between the MCU control inputs and the DAC control/clock-select logic in the SNOS top level. Synchronizes and debounces the requested configuration, then runs mute → reset → switch → settle → release → unmute. Performs the same settle/release/unmute on power-up.

## Interface
Parameters:
- CFG_W, 8: width of the configuration bundle ({mclk_sel[2:0], j10, dsd_on, f[1:0], 44_48}).
- CFG_RESET, 8'h00: `cfg_out` value at reset.
- STABLE_CYC, 4096: cycles the synchronized request must be unchanged before it is accepted (≥1).
- MUTE_CYC, 65536: mute-before-reset and reset-release-to-unmute time (≥1).
- RESET_CYC, 1024: reset-hold time before the switch (≥1).
- SETTLE_CYC, 262144: reset-hold time after the switch, for PLL/clock settling (≥1).

Ports:
- clk  in  1  system clock, the same `clk` that drives the LED indicators.
- resetn  in  1  asynchronous, active-low reset.
- cfg_in  in  CFG_W  requested configuration; asynchronous to `clk`.
- mcu_mute  in  1  MCU mute request, active-high; asynchronous.
- mcu_rst  in  1  MCU DAC reset request, active-high; asynchronous.
- cfg_out  out  CFG_W  applied configuration; drives clock select and DAC control decode.
- dac_mute  out  1  active-high mute to the DAC (before j[2] polarity).
- dac_rst  out  1  active-high DAC reset (before j[6] polarity).
- busy  out  1  high while a sequence is in progress.

## Operation
- `cfg_in`, `mcu_mute` and `mcu_rst` each pass through a 2-flop synchronizer. The synchronized versions are `cfg_s`, `mute_s` and `rst_s`.
- FSM states: IDLE, DEBOUNCE, MUTE, RESET, SWITCH, SETTLE, RELEASE.
- One down-counter serves all states. Width is $clog2 of the largest parameter, plus 1. It is loaded on every state entry.
- IDLE:
  - `cfg_s != cfg_out` → load `cand <= cfg_s`, then go to DEBOUNCE.
- DEBOUNCE:
  - `cfg_s == cand` for STABLE_CYC consecutive cycles → MUTE.
  - `cfg_s` differs from `cand` and also from `cfg_out` → reload `cand` and restart the count.
  - `cfg_s == cfg_out` (glitch) → back to IDLE; no output change.
- MUTE: MUTE_CYC cycles → RESET.
- RESET: RESET_CYC cycles → SWITCH.
- SWITCH: 1 cycle, with `cfg_out <= cand` → SETTLE.
- SETTLE: SETTLE_CYC cycles → RELEASE.
- RELEASE: MUTE_CYC cycles → IDLE.
- Changes to `cfg_s` from MUTE onward are ignored until the FSM is back in IDLE. IDLE then sees the mismatch and starts a new sequence.
- Output equations:
  - `dac_mute` = `mute_s` OR state ∈ {MUTE, RESET, SWITCH, SETTLE, RELEASE}.
  - `dac_rst` = `rst_s` OR state ∈ {RESET, SWITCH, SETTLE}.
  - `busy` = state ∉ {IDLE, DEBOUNCE}.
- The MCU requests only add to the sequencer's own mute and reset. They never shorten a sequence.

## Timing
- All outputs are registered and decoded from next-state, so each output is valid in the first cycle of its state.
- Reset values:
  - state = SETTLE, counter = SETTLE_CYC, `cand` = `cfg_out` = CFG_RESET.
  - `dac_mute` = 1, `dac_rst` = 1, `busy` = 1, synchronizers = 0.
- Power-up sequence, counted from the first rising edge after `resetn` rises:
  - `dac_rst` falls after SETTLE_CYC cycles.
  - `dac_mute` falls MUTE_CYC cycles after that.
  - `busy` falls in the same cycle as `dac_mute`.
- Request latency: `cfg_in` set up before edge E gives `cfg_s` at E+1 and DEBOUNCE at E+2. From there:
  - MUTE begins at E+2+S.
  - RESET begins at E+2+S+M.
  - `cfg_out` changes at E+2+S+M+R.
  - `dac_rst` falls at E+3+S+M+R+T.
  - IDLE (unmute, `busy` low) is reached at E+3+S+2M+R+T.
- Asserting `resetn` at any point aborts the sequence immediately and restores the reset values. There is no partial `cfg_out` update.
- Timed states last exactly their parameter value. Parameters <1 are illegal and are checked with an elaboration assertion.

## Structure
- Package `common` gets:
  - `typedef enum logic [2:0] seq_state_t` for the FSM states.
  - Default timing localparams.
- Sub-module `sync_2ff`, parameterized by width, used three times (`cfg_in`, `mcu_mute`, `mcu_rst`).
- FSM, counter and output registers live in `dac_mode_sequencer`.

## Test plan
All scenarios use STABLE=4, MUTE=8, RESET=4, SETTLE=16, CFG_RESET=8'h00.
- Power-up: release `resetn` at edge 0 → `dac_rst` 1→0 at edge 16; `dac_mute` and `busy` 1→0 at edge 24; `cfg_out` = 00 throughout.
- Single change: `cfg_in` = 8'h05 before edge E, in IDLE → `dac_mute`↑ at E+6, `dac_rst`↑ at E+14, `cfg_out` = 05 at E+18, `dac_rst`↓ at E+35, `dac_mute`/`busy`↓ at E+43.
- Glitch: `cfg_in` 00→05→00 with 05 held for 2 cycles → DEBOUNCE entered then left; `dac_mute`, `dac_rst`, `cfg_out` unchanged.
- Change during SETTLE: `cfg_in` = 8'h0A while in SETTLE of a 00→05 sequence → first sequence completes with `cfg_out` = 05; DEBOUNCE starts the cycle after IDLE; `cfg_out` = 0A after a full second sequence.
- MCU overrides: `mcu_mute` = 1 in IDLE → `dac_mute`↑ 3 edges later, `busy` stays 0; `mcu_rst` = 1 during RELEASE → `dac_rst` high and timing unchanged.
- Reset mid-sequence: drop `resetn` during RESET → all outputs return to reset values asynchronously; `cfg_out` = 00; the power-up timing of scenario 1 repeats.
